// File: rtl/alu_exec_pkg.sv
// Shared opcodes, FSM state type and iteration count for the alu_exec stage.
// Opcode OP_DIV is only legal when the build defines ALU_EXEC_DIV_EN.
package alu_exec_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam int unsigned ITER_CYCLES = 32;
  localparam int unsigned CNT_W       = $clog2(ITER_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier; with ALU_EXEC_DIV_EN also a restoring
// divider sharing the same registers and counter. o_done/o_result are combinational.
module seq_muldiv
  import alu_exec_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
`ifdef ALU_EXEC_DIV_EN
  input  logic         i_div,
`endif
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_result
);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_acc;   // product accumulator / partial remainder
  logic [W-1:0]     r_x;     // multiplicand / divisor
  logic [W-1:0]     r_y;     // multiplier / dividend-then-quotient
  logic [W-1:0]     w_mul_acc;

  assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);
  assign o_done    = r_busy && (r_cnt == CNT_W'(ITER_CYCLES - 1));

`ifdef ALU_EXEC_DIV_EN
  logic         r_div;
  logic [W:0]   w_rem_sh;
  logic [W:0]   w_trial;
  logic         w_q_bit;
  logic [W-1:0] w_rem_nxt;
  logic [W-1:0] w_quo_nxt;

  // Divide by zero needs no special case: every trial succeeds, quotient is all ones.
  assign w_rem_sh  = {r_acc, r_y[W-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_x};
  assign w_q_bit   = ~w_trial[W];
  assign w_rem_nxt = w_q_bit ? w_trial[W-1:0] : w_rem_sh[W-1:0];
  assign w_quo_nxt = {r_y[W-2:0], w_q_bit};
  assign o_result  = r_div ? w_quo_nxt : w_mul_acc;
`else
  assign o_result  = w_mul_acc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_x    <= '0;
      r_y    <= '0;
`ifdef ALU_EXEC_DIV_EN
      r_div  <= 1'b0;
`endif
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_acc  <= '0;
`ifdef ALU_EXEC_DIV_EN
      r_div  <= i_div;
      r_x    <= i_div ? i_b : i_a;
      r_y    <= i_div ? i_a : i_b;
`else
      r_x    <= i_a;
      r_y    <= i_b;
`endif
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      if (r_div) begin
        r_acc <= w_rem_nxt;
        r_y   <= w_quo_nxt;
      end else begin
        r_acc <= w_mul_acc;
        r_x   <= r_x << 1;
        r_y   <= r_y >> 1;
      end
`else
      r_acc <= w_mul_acc;
      r_x   <= r_x << 1;
      r_y   <= r_y >> 1;
`endif
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute/writeback stage: valid/ready issue, single-cycle ALU, iterative MUL
// (and DIV when ALU_EXEC_DIV_EN is defined), registered regfile write triple.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              write_enabled,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              pending_valid,
  output logic [ADDR_W-1:0] pending_addr,
  output logic              illegal_op
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_pend;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_illegal;

  logic              w_accept;
  logic              w_op_legal;
  logic              w_dest_ok;
  logic              w_is_iter;
  logic              w_start;
  logic [DATA_W-1:0] w_alu;
  logic              w_md_done;
  logic [DATA_W-1:0] w_md_result;

  assign issue_ready   = (r_state == IDLE);
  assign w_accept      = issue_valid & issue_ready;
  assign w_dest_ok     = (32'(dest_addr) < 32'(NUM_REGS));
`ifdef ALU_EXEC_DIV_EN
  assign w_op_legal    = (opcode <= OP_DIV);
  assign w_is_iter     = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
  assign w_op_legal    = (opcode <= OP_MUL);
  assign w_is_iter     = (opcode == OP_MUL);
`endif
  assign w_start       = w_accept & w_op_legal & w_dest_ok & w_is_iter;

  assign write_enabled = r_we;
  assign write_addr    = r_waddr;
  assign write_data    = r_wdata;
  assign pending_valid = r_pend;
  assign pending_addr  = r_paddr;
  assign illegal_op    = r_illegal;

  always_comb begin
    w_alu = '0;
    case (opcode)
      OP_ADD:  w_alu = operand_a + operand_b;
      OP_SUB:  w_alu = operand_a - operand_b;
      OP_AND:  w_alu = operand_a & operand_b;
      OP_OR:   w_alu = operand_a | operand_b;
      OP_XOR:  w_alu = operand_a ^ operand_b;
      OP_SHL:  w_alu = operand_a << operand_b[4:0];
      OP_SHR:  w_alu = operand_a >> operand_b[4:0];
      OP_MOV:  w_alu = operand_a;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start)   w_state_nxt = ITER;
      ITER:    if (w_md_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  seq_muldiv #(
    .W (DATA_W)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
`ifdef ALU_EXEC_DIV_EN
    .i_div    (opcode == OP_DIV),
`endif
    .i_a      (operand_a),
    .i_b      (operand_b),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // The last iteration and the writeback share one edge, so the write pulse
  // lands exactly 32 cycles after the start of ITER.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_pend    <= 1'b0;
      r_paddr   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
      if (w_accept) begin
        if (!(w_op_legal && w_dest_ok)) begin
          r_illegal <= 1'b1;
        end else if (w_is_iter) begin
          r_pend  <= 1'b1;
          r_paddr <= dest_addr;
        end else begin
          r_we    <= 1'b1;
          r_waddr <= dest_addr;
          r_wdata <= w_alu;
        end
      end
      if ((r_state == ITER) && w_md_done) begin
        r_we    <= 1'b1;
        r_waddr <= r_paddr;
        r_wdata <= w_md_result;
        r_pend  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus random traffic
// compared cycle by cycle against a timeline-based reference model.
module tb_alu_exec;

  localparam int NCYC = 2600;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  opcode;
  logic [5:0]  dest_addr;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        write_enabled;
  logic [5:0]  write_addr;
  logic [31:0] write_data;
  logic        pending_valid;
  logic [5:0]  pending_addr;
  logic        illegal_op;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ready_at = 0;

  bit          exp_we   [NCYC];
  logic [5:0]  exp_addr [NCYC];
  logic [31:0] exp_data [NCYC];
  bit          exp_ill  [NCYC];
  bit          exp_pend [NCYC];
  logic [5:0]  exp_paddr[NCYC];

  alu_exec #(
    .DATA_W   (32),
    .ADDR_W   (6),
    .NUM_REGS (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .opcode        (opcode),
    .dest_addr     (dest_addr),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .write_enabled (write_enabled),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .pending_valid (pending_valid),
    .pending_addr  (pending_addr),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [3:0] op, input logic [5:0] d);
    bit op_ok;
`ifdef ALU_EXEC_DIV_EN
    op_ok = (op <= 4'd9);
`else
    op_ok = (op <= 4'd8);
`endif
    return op_ok && (d < 6'd8);
  endfunction

  function automatic logic [31:0] ref_calc(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return x << y[4:0];
      4'd6:    return x >> y[4:0];
      4'd7:    return x;
      4'd8:    return x * y;
      default: return (y == 0) ? 32'hFFFF_FFFF : x / y;
    endcase
  endfunction

  // Drive one cycle of inputs, update the expected timeline, then check the next cycle.
  task automatic cycle(input logic v, input logic rst, input logic [3:0] op,
                       input logic [5:0] d, input logic [31:0] x, input logic [31:0] y);
    issue_valid = v;
    reset       = rst;
    opcode      = op;
    dest_addr   = d;
    operand_a   = x;
    operand_b   = y;
    if (rst) begin
      for (int k = cyc + 1; k < NCYC; k++) begin
        exp_we[k]   = 1'b0;
        exp_ill[k]  = 1'b0;
        exp_pend[k] = 1'b0;
      end
      ready_at = cyc + 1;
    end else if (v && cyc >= ready_at) begin
      if (!ref_legal(op, d)) begin
        exp_ill[cyc + 1] = 1'b1;
      end else if (op == 4'd8 || op == 4'd9) begin
        for (int k = cyc + 1; k <= cyc + 32; k++) begin
          exp_pend[k]  = 1'b1;
          exp_paddr[k] = d;
        end
        exp_we[cyc + 33]   = 1'b1;
        exp_addr[cyc + 33] = d;
        exp_data[cyc + 33] = ref_calc(op, x, y);
        ready_at = cyc + 33;
      end else begin
        exp_we[cyc + 1]   = 1'b1;
        exp_addr[cyc + 1] = d;
        exp_data[cyc + 1] = ref_calc(op, x, y);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("issue_ready", 32'(issue_ready), 32'(cyc >= ready_at));
    check("write_enabled", 32'(write_enabled), 32'(exp_we[cyc]));
    check("illegal_op", 32'(illegal_op), 32'(exp_ill[cyc]));
    check("pending_valid", 32'(pending_valid), 32'(exp_pend[cyc]));
    if (exp_we[cyc]) begin
      check("write_addr", 32'(write_addr), 32'(exp_addr[cyc]));
      check("write_data", write_data, exp_data[cyc]);
    end
    if (exp_pend[cyc]) check("pending_addr", 32'(pending_addr), 32'(exp_paddr[cyc]));
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_write_addr", 32'(write_addr), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_pending_addr", 32'(pending_addr), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NCYC; k++) begin
      exp_we[k] = 1'b0; exp_ill[k] = 1'b0; exp_pend[k] = 1'b0;
      exp_addr[k] = '0; exp_data[k] = '0; exp_paddr[k] = '0;
    end

    cycle(1'b0, 1'b1, 4'd0, 6'd0, 32'd0, 32'd0);
    cycle(1'b0, 1'b1, 4'd0, 6'd0, 32'd0, 32'd0);
    check_reset_values();

    cycle(1'b1, 1'b0, 4'd0, 6'd3, 32'd5, 32'd7);
    check("add_result", write_data, 32'd12);
    idle(2);

    cycle(1'b1, 1'b0, 4'd1, 6'd1, 32'd0, 32'd1);
    cycle(1'b1, 1'b0, 4'd5, 6'd2, 32'd1, 32'd31);
    idle(2);

    cycle(1'b1, 1'b0, 4'd8, 6'd4, 32'h0001_0000, 32'h0001_0001);
    for (int i = 0; i < 33; i++) cycle(1'b1, 1'b0, 4'd0, 6'd5, 32'd40, 32'd2);
    idle(3);

    cycle(1'b1, 1'b0, 4'd12, 6'd0, 32'd1, 32'd1);
    cycle(1'b1, 1'b0, 4'd0, 6'd9, 32'd1, 32'd1);
    cycle(1'b1, 1'b0, 4'd9, 6'd6, 32'd100, 32'd7);
    idle(34);
    cycle(1'b1, 1'b0, 4'd9, 6'd7, 32'd12345, 32'd0);
    idle(34);

    cycle(1'b1, 1'b1, 4'd0, 6'd1, 32'd9, 32'd9);
    idle(1);

    cycle(1'b1, 1'b0, 4'd8, 6'd3, 32'd1234, 32'd5678);
    idle(9);
    cycle(1'b0, 1'b1, 4'd0, 6'd0, 32'd0, 32'd0);
    check_reset_values();
    idle(40);

    while (cyc < NCYC - 60) begin
      logic [3:0] op;
      op = (($urandom_range(0, 3)) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0), op,
            6'($urandom_range(0, 9)), $urandom(),
            ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom());
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
